hilo_mdu_ctrl: RTL and testbench

Multiply/divide sequencer and HI/LO register owner for the EX stage.
- Accepts decoded mult/div/mthi/mtlo operations from the instruction in EX.
- Runs a fixed-latency multiplier or a 32-iteration radix-2 restoring divider.
- Stalls the pipeline while busy and commits HI/LO only when the EX instruction advances unflushed.
- Supplies architectural HI/LO to mfhi/mflo reads.

---
 rtl/hilo_mdu_ctrl_pkg.sv | 21 ++
 rtl/mdu_div_core.sv | 81 ++++++++
 rtl/hilo_mdu_ctrl.sv | 167 ++++++++++++++++
 tb/tb_hilo_mdu_ctrl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hilo_mdu_ctrl_pkg.sv
// Shared types and constants for the HI/LO multiply/divide sequencer.
// Holds the FSM encoding, datapath widths and the operand magnitude helper.
package hilo_mdu_ctrl_pkg;

   localparam int XLEN     = 32;
   localparam int PROD_W   = 2 * XLEN;
   localparam int DIV_ITER = 32;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DIV  = 2'd2,
      S_DONE = 2'd3
   } mdu_state_e;

   // Two's-complement magnitude when the operand is treated as signed.
   function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] v, input logic sgn);
      return (sgn && v[XLEN-1]) ? -v : v;
   endfunction

endpackage

// File: rtl/mdu_div_core.sv
// Radix-2 restoring divider on magnitudes: ITER shift/subtract cycles, then one
// sign-fix cycle in which valid is high and the signed results are presented.
module mdu_div_core
   import hilo_mdu_ctrl_pkg::*;
#(
   parameter int ITER = DIV_ITER
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            go,
   input  logic            abort,
   input  logic [XLEN-1:0] a_mag,
   input  logic [XLEN-1:0] b_mag,
   input  logic            neg_q,
   input  logic            neg_r,
   output logic            valid,
   output logic [XLEN-1:0] quotient,
   output logic [XLEN-1:0] remainder
);

   localparam int CNT_W = $clog2(ITER + 1);

   logic             busy;
   logic [CNT_W-1:0] cnt;
   logic [XLEN-1:0]  rem;
   logic [XLEN-1:0]  quo;
   logic [XLEN-1:0]  dvs;
   logic             neg_q_q;
   logic             neg_r_q;
   logic [XLEN:0]    rem_sh;
   logic [XLEN:0]    diff;

   // Trial subtraction; a clear top bit means the partial remainder covers the divisor.
   always_comb begin
      rem_sh = {rem, quo[XLEN-1]};
      diff   = rem_sh - {1'b0, dvs};
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy    <= 1'b0;
         cnt     <= '0;
         rem     <= '0;
         quo     <= '0;
         dvs     <= '0;
         neg_q_q <= 1'b0;
         neg_r_q <= 1'b0;
      end else if (abort) begin
         busy <= 1'b0;
      end else if (go) begin
         busy    <= 1'b1;
         cnt     <= '0;
         rem     <= '0;
         quo     <= a_mag;
         dvs     <= b_mag;
         neg_q_q <= neg_q;
         neg_r_q <= neg_r;
      end else if (busy) begin
         if (cnt == CNT_W'(ITER)) begin
            busy <= 1'b0;
         end else begin
            cnt <= cnt + CNT_W'(1);
            if (!diff[XLEN]) begin
               rem <= diff[XLEN-1:0];
               quo <= {quo[XLEN-2:0], 1'b1};
            end else begin
               rem <= rem_sh[XLEN-1:0];
               quo <= {quo[XLEN-2:0], 1'b0};
            end
         end
      end
   end

   always_comb begin
      valid     = busy && (cnt == CNT_W'(ITER));
      quotient  = neg_q_q ? -quo : quo;
      remainder = neg_r_q ? -rem : rem;
   end

endmodule

// File: rtl/hilo_mdu_ctrl.sv
// EX-stage multiply/divide sequencer and owner of architectural HI/LO.
// Stalls the pipe while computing and commits only when EX advances unflushed.
module hilo_mdu_ctrl
   import hilo_mdu_ctrl_pkg::*;
#(
   parameter int MUL_LAT  = 2,
   parameter int DIV_ITER = hilo_mdu_ctrl_pkg::DIV_ITER
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            op_div,
   input  logic            op_sign,
   input  logic [XLEN-1:0] src_a,
   input  logic [XLEN-1:0] src_b,
   input  logic [1:0]      hilowen,
   input  logic [XLEN-1:0] wdata,
   input  logic            ex_go,
   input  logic            flush,
   output logic            stall,
   output logic [XLEN-1:0] hi,
   output logic [XLEN-1:0] lo
);

   mdu_state_e        state;
   mdu_state_e        state_nxt;
   logic              accept;
   logic              commit;
   logic              mtx_wr;
   logic              mul_last;
   logic [2:0]        mul_cnt;
   logic [XLEN-1:0]   op_a;
   logic [XLEN-1:0]   op_b;
   logic              op_sign_q;
   logic              op_div_q;
   logic              div_zero;
   logic [PROD_W-1:0] ext_a;
   logic [PROD_W-1:0] ext_b;
   logic [PROD_W-1:0] prod;
   logic [PROD_W-1:0] prod_pipe [MUL_LAT];
   logic              div_valid;
   logic [XLEN-1:0]   core_q;
   logic [XLEN-1:0]   core_r;
   logic [XLEN-1:0]   div_hi;
   logic [XLEN-1:0]   div_lo;
   logic [XLEN-1:0]   res_hi;
   logic [XLEN-1:0]   res_lo;

   always_comb begin
      accept   = (state == S_IDLE) && start && !flush;
      commit   = (state == S_DONE) && ex_go && !flush;
      mtx_wr   = (state == S_IDLE) && ex_go && !flush && !start;
      mul_last = (mul_cnt == 3'(MUL_LAT));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   // NOTE: default assignment first so no path through the case infers a latch.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (accept) state_nxt = op_div ? S_DIV : S_MUL;
         S_MUL: begin
            if (flush)         state_nxt = S_IDLE;
            else if (mul_last) state_nxt = S_DONE;
         end
         S_DIV: begin
            if (flush)          state_nxt = S_IDLE;
            else if (div_valid) state_nxt = S_DONE;
         end
         S_DONE:  if (flush || ex_go) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      stall = 1'b0;
      case (state)
         S_IDLE:       stall = start && !flush;
         S_MUL, S_DIV: stall = 1'b1;
         default:      stall = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_a      <= '0;
         op_b      <= '0;
         op_sign_q <= 1'b0;
         op_div_q  <= 1'b0;
         div_zero  <= 1'b0;
         mul_cnt   <= '0;
         div_hi    <= '0;
         div_lo    <= '0;
      end else begin
         if (accept) begin
            op_a      <= src_a;
            op_b      <= src_b;
            op_sign_q <= op_sign;
            op_div_q  <= op_div;
            div_zero  <= (src_b == '0);
            mul_cnt   <= 3'd1;
         end else if (state == S_MUL && !mul_last) begin
            mul_cnt <= mul_cnt + 3'd1;
         end
         if (state == S_DIV && div_valid) begin
            div_lo <= div_zero ? '1   : core_q;
            div_hi <= div_zero ? op_a : core_r;
         end
      end
   end

   // The low 64 bits of a 64x64 product of extended operands equal the 33x33 product.
   always_comb begin
      ext_a = {{XLEN{op_sign_q & op_a[XLEN-1]}}, op_a};
      ext_b = {{XLEN{op_sign_q & op_b[XLEN-1]}}, op_b};
      prod  = ext_a * ext_b;
   end

   // NOTE: the product pipeline is small and its contents are architecturally defined at reset, so it is reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < MUL_LAT; i++) prod_pipe[i] <= '0;
      end else if (state == S_MUL) begin
         prod_pipe[0] <= prod;
         for (int i = 1; i < MUL_LAT; i++) prod_pipe[i] <= prod_pipe[i-1];
      end
   end

   mdu_div_core #(
      .ITER(DIV_ITER)
   ) u_div (
      .clk      (clk),
      .rst      (rst),
      .go       (accept && op_div),
      .abort    ((state == S_DIV) && flush),
      .a_mag    (abs_val(src_a, op_sign)),
      .b_mag    (abs_val(src_b, op_sign)),
      .neg_q    (op_sign && (src_a[XLEN-1] ^ src_b[XLEN-1])),
      .neg_r    (op_sign && src_a[XLEN-1]),
      .valid    (div_valid),
      .quotient (core_q),
      .remainder(core_r)
   );

   always_comb begin
      res_hi = op_div_q ? div_hi : prod_pipe[MUL_LAT-1][PROD_W-1:XLEN];
      res_lo = op_div_q ? div_lo : prod_pipe[MUL_LAT-1][XLEN-1:0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hi <= '0;
         lo <= '0;
      end else if (commit) begin
         hi <= res_hi;
         lo <= res_lo;
      end else if (mtx_wr) begin
         if (hilowen[1]) hi <= wdata;
         if (hilowen[0]) lo <= wdata;
      end
   end

endmodule

// File: tb/tb_hilo_mdu_ctrl.sv
// Self-checking bench for hilo_mdu_ctrl: vector table through a scoreboard,
// plus hand sequences for mthi/mtlo, flushes, DONE hold and async reset.
module tb_hilo_mdu_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        op_div;
   logic        op_sign;
   logic [31:0] src_a;
   logic [31:0] src_b;
   logic [1:0]  hilowen;
   logic [31:0] wdata;
   logic        ex_go;
   logic        flush;
   logic        stall;
   logic [31:0] hi;
   logic [31:0] lo;

   always #5 clk = ~clk;

   hilo_mdu_ctrl #(
      .MUL_LAT (2),
      .DIV_ITER(32)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .op_div (op_div),
      .op_sign(op_sign),
      .src_a  (src_a),
      .src_b  (src_b),
      .hilowen(hilowen),
      .wdata  (wdata),
      .ex_go  (ex_go),
      .flush  (flush),
      .stall  (stall),
      .hi     (hi),
      .lo     (lo)
   );

   typedef struct {
      logic        op_div;
      logic        op_sign;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp_hi;
      logic [31:0] exp_lo;
      int          exp_stall;
   } vec_t;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
   } res_t;

   localparam int NVEC = 16;

   vec_t vecs [NVEC];
   res_t sb_q [$];
   int   checks = 0;
   int   errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic d, input logic s, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] h, input logic [31:0] l);
      vec_t v;
      v.op_div    = d;
      v.op_sign   = s;
      v.a         = a;
      v.b         = b;
      v.exp_hi    = h;
      v.exp_lo    = l;
      v.exp_stall = d ? 34 : 3;
      return v;
   endfunction

   task automatic push_exp(input logic [31:0] h, input logic [31:0] l);
      res_t e;
      e.hi = h;
      e.lo = l;
      sb_q.push_back(e);
   endtask

   // Entered just after a negedge; returns 1ns after the negedge where stall is low.
   task automatic wait_stall_low(input string name, output int n);
      n = 0;
      #1;
      while (stall === 1'b1 && n < 200) begin
         n++;
         @(negedge clk);
         #1;
      end
      if (n >= 200) begin
         errors++;
         $display("FAIL %s: stall stuck high after %0d cycles", name, n);
      end
   endtask

   task automatic drive_op(input vec_t v);
      start   = 1'b1;
      op_div  = v.op_div;
      op_sign = v.op_sign;
      src_a   = v.a;
      src_b   = v.b;
      ex_go   = 1'b0;
   endtask

   // Called in DONE: let EX advance, then compare against the scoreboard head.
   task automatic commit_and_check(input string name);
      res_t e;
      start = 1'b0;
      ex_go = 1'b1;
      @(negedge clk);
      ex_go = 1'b0;
      if (sb_q.size() == 0) begin
         errors++;
         $display("FAIL %s: result committed with empty scoreboard", name);
      end else begin
         e = sb_q.pop_front();
         check({name, " hi_lo"}, {hi, lo}, {e.hi, e.lo});
      end
   endtask

   task automatic run_op(input vec_t v, input string name);
      int n;
      drive_op(v);
      push_exp(v.exp_hi, v.exp_lo);
      wait_stall_low(name, n);
      check({name, " stall_cycles"}, 64'(n), 64'(v.exp_stall));
      commit_and_check(name);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int n;
      vec_t v;
      rst = 1'b1; start = 1'b0; op_div = 1'b0; op_sign = 1'b0;
      src_a = '0; src_b = '0; hilowen = '0; wdata = '0; ex_go = 1'b0; flush = 1'b0;

      vecs[0]  = mk(0, 1, 32'hFFFF_FFFE, 32'd3,        32'hFFFF_FFFF, 32'hFFFF_FFFA);
      vecs[1]  = mk(0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
      vecs[2]  = mk(0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001);
      vecs[3]  = mk(0, 1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
      vecs[4]  = mk(0, 0, 32'h8000_0000, 32'd2,        32'h0000_0001, 32'h0000_0000);
      vecs[5]  = mk(0, 1, 32'h8000_0000, 32'd2,        32'hFFFF_FFFF, 32'h0000_0000);
      vecs[6]  = mk(1, 0, 32'd100,       32'd7,        32'd2,         32'd14);
      vecs[7]  = mk(1, 1, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD);
      vecs[8]  = mk(1, 1, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD);
      vecs[9]  = mk(1, 1, 32'h1234_5678, 32'd0,        32'h1234_5678, 32'hFFFF_FFFF);
      vecs[10] = mk(1, 1, 32'hFFFF_FFF9, 32'd0,        32'hFFFF_FFF9, 32'hFFFF_FFFF);
      vecs[11] = mk(1, 1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
      vecs[12] = mk(1, 0, 32'hFFFF_FFFF, 32'd1,        32'h0000_0000, 32'hFFFF_FFFF);
      vecs[13] = mk(1, 0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000);
      vecs[14] = mk(1, 0, 32'hFFFF_FFF9, 32'd2,        32'h0000_0001, 32'h7FFF_FFFC);
      vecs[15] = mk(1, 0, 32'hDEAD_BEEF, 32'h10,       32'h0000_000F, 32'h0DEA_DBEE);

      #12;
      check("reset hi_lo", {hi, lo}, 64'h0);
      check("reset stall", 64'(stall), 64'h0);
      @(negedge clk);
      rst = 1'b0;

      // Back-to-back table: each op is driven in the IDLE cycle right after the previous commit.
      for (int i = 0; i < NVEC; i++) run_op(vecs[i], $sformatf("vec%0d", i));

      // mthi / mtlo, then a flushed write that must be dropped.
      hilowen = 2'b10; wdata = 32'hAAAA_AAAA; ex_go = 1'b1;
      @(negedge clk);
      check("mthi", 64'(hi), 64'hAAAA_AAAA);
      hilowen = 2'b01; wdata = 32'h5555_5555;
      @(negedge clk);
      check("mtlo", {hi, lo}, {32'hAAAA_AAAA, 32'h5555_5555});
      hilowen = 2'b11; wdata = 32'h0; flush = 1'b1;
      @(negedge clk);
      hilowen = 2'b00; flush = 1'b0; ex_go = 1'b0;
      check("mthi_mtlo flushed", {hi, lo}, {32'hAAAA_AAAA, 32'h5555_5555});

      // start together with flush is not accepted.
      v = vecs[6];
      drive_op(v);
      flush = 1'b1;
      #1;
      check("start_flush stall", 64'(stall), 64'h0);
      @(negedge clk);
      #1;
      check("start_flush no accept", 64'(stall), 64'h0);
      start = 1'b0; flush = 1'b0;

      // Flush at DIV cycle 10.
      @(negedge clk);
      drive_op(v);
      for (int i = 0; i < 10; i++) @(negedge clk);
      #1;
      check("div_flush busy", 64'(stall), 64'h1);
      flush = 1'b1; start = 1'b0;
      @(negedge clk);
      flush = 1'b0;
      #1;
      check("div_flush stall", 64'(stall), 64'h0);
      repeat (3) @(negedge clk);
      check("div_flush hi_lo", {hi, lo}, {32'hAAAA_AAAA, 32'h5555_5555});
      check("div_flush idle", 64'(stall), 64'h0);

      // DONE held 5 cycles with start still high: no relaunch, no write.
      v = mk(0, 1, 32'd5, 32'd6, 32'd0, 32'd30);
      drive_op(v);
      push_exp(v.exp_hi, v.exp_lo);
      wait_stall_low("done_hold", n);
      check("done_hold stall_cycles", 64'(n), 64'(v.exp_stall));
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         #1;
         check($sformatf("done_hold c%0d stall", i), 64'(stall), 64'h0);
         check($sformatf("done_hold c%0d hi_lo", i), {hi, lo}, {32'hAAAA_AAAA, 32'h5555_5555});
      end
      commit_and_check("done_hold");
      @(negedge clk);
      check("done_hold after", {hi, lo}, {32'd0, 32'd30});

      // Flush in DONE discards the result.
      v = mk(0, 1, 32'd7, 32'd8, 32'd0, 32'd56);
      drive_op(v);
      wait_stall_low("done_flush", n);
      check("done_flush stall_cycles", 64'(n), 64'(v.exp_stall));
      flush = 1'b1; start = 1'b0;
      @(negedge clk);
      flush = 1'b0;
      #1;
      check("done_flush hi_lo", {hi, lo}, {32'd0, 32'd30});
      check("done_flush stall", 64'(stall), 64'h0);

      // Async reset mid-MUL clears everything without a clock edge.
      @(negedge clk);
      drive_op(mk(0, 0, 32'd9, 32'd9, 32'd0, 32'd81));
      @(posedge clk);
      #2;
      start = 1'b0;
      rst   = 1'b1;
      #1;
      check("rst_mul hi_lo", {hi, lo}, 64'h0);
      check("rst_mul stall", 64'(stall), 64'h0);
      @(negedge clk);
      rst = 1'b0;
      run_op(vecs[0], "post_rst mult");

      check("scoreboard drained", 64'(sb_q.size()), 64'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
